// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SIZE_W = 2;

  localparam logic [SIZE_W-1:0] MEM_SIZE_BYTE = 2'd1;
  localparam logic [SIZE_W-1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  // Winner selection: 0 = port 0, 1 = port 1. A lone pending port always wins.
  function automatic logic arb_pick(input logic fixed_prio, input logic p0_pend,
                                    input logic p1_pend, input logic rr_ptr);
    if (p0_pend && p1_pend) begin
      return fixed_prio ? 1'b0 : rr_ptr;
    end
    return p1_pend;
  endfunction

endpackage

// File: rtl/mem_arb_port.sv
// One-entry request buffer for a single arbiter port.
module mem_arb_port
  import mem_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              exec,
  input  logic              write,
  input  logic [SIZE_W-1:0] size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              complete,
  output logic              ready,
  output logic              pending,
  output mem_req_t          req
);

  // Capture on exec while ready; free the slot on completion. ready rises
  // one edge after reset release because it simply tracks !pending.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      ready   <= 1'b0;
      pending <= 1'b0;
      req     <= '0;
    end else if (complete) begin
      ready   <= 1'b1;
      pending <= 1'b0;
    end else if (exec && ready) begin
      ready     <= 1'b0;
      pending   <= 1'b1;
      req.write <= write;
      req.size  <= size;
      req.addr  <= addr;
      req.data  <= data;
    end else begin
      ready <= !pending;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single shared memory request interface.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              I_clk,
  input  logic              I_reset,
  input  logic              I_p0_exec,
  input  logic              I_p0_write,
  input  logic [SIZE_W-1:0] I_p0_size,
  input  logic [ADDR_W-1:0] I_p0_addr,
  input  logic [DATA_W-1:0] I_p0_data,
  output logic              O_p0_ready,
  output logic [DATA_W-1:0] O_p0_data,
  output logic              O_p0_data_ready,
  input  logic              I_p1_exec,
  input  logic              I_p1_write,
  input  logic [SIZE_W-1:0] I_p1_size,
  input  logic [ADDR_W-1:0] I_p1_addr,
  input  logic [DATA_W-1:0] I_p1_data,
  output logic              O_p1_ready,
  output logic [DATA_W-1:0] O_p1_data,
  output logic              O_p1_data_ready,
  input  logic              MEM_ready,
  input  logic [DATA_W-1:0] MEM_data_in,
  input  logic              MEM_data_ready,
  output logic              MEM_exec,
  output logic              MEM_write,
  output logic [SIZE_W-1:0] MEM_size,
  output logic [ADDR_W-1:0] MEM_addr,
  output logic [DATA_W-1:0] MEM_data_out
);

  arb_state_t state;
  logic       owner;
  logic       rr_ptr;

  logic       p0_pending, p1_pending;
  mem_req_t   p0_req, p1_req;
  logic       grant_c;
  mem_req_t   grant_req_c;
  logic       done_c;
  logic       p0_complete_c, p1_complete_c;

  mem_arb_port u_port0 (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .exec     (I_p0_exec),
    .write    (I_p0_write),
    .size     (I_p0_size),
    .addr     (I_p0_addr),
    .data     (I_p0_data),
    .complete (p0_complete_c),
    .ready    (O_p0_ready),
    .pending  (p0_pending),
    .req      (p0_req)
  );

  mem_arb_port u_port1 (
    .I_clk    (I_clk),
    .I_reset  (I_reset),
    .exec     (I_p1_exec),
    .write    (I_p1_write),
    .size     (I_p1_size),
    .addr     (I_p1_addr),
    .data     (I_p1_data),
    .complete (p1_complete_c),
    .ready    (O_p1_ready),
    .pending  (p1_pending),
    .req      (p1_req)
  );

  // Arbitration result and completion detection for the current owner.
  assign grant_c       = arb_pick(FIXED_PRIO != 0, p0_pending, p1_pending, rr_ptr);
  assign grant_req_c   = grant_c ? p1_req : p0_req;
  assign done_c        = (state == ST_WAIT) && (MEM_write ? MEM_ready : MEM_data_ready);
  assign p0_complete_c = done_c && !owner;
  assign p1_complete_c = done_c && owner;

  // Arbiter FSM; memory request fields stay loaded until the next grant.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state           <= ST_IDLE;
      owner           <= 1'b0;
      rr_ptr          <= 1'b0;
      MEM_exec        <= 1'b0;
      MEM_write       <= 1'b0;
      MEM_size        <= '0;
      MEM_addr        <= '0;
      MEM_data_out    <= '0;
      O_p0_data       <= '0;
      O_p1_data       <= '0;
      O_p0_data_ready <= 1'b0;
      O_p1_data_ready <= 1'b0;
    end else begin
      MEM_exec        <= 1'b0;
      O_p0_data_ready <= 1'b0;
      O_p1_data_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((p0_pending || p1_pending) && MEM_ready) begin
            owner        <= grant_c;
            MEM_write    <= grant_req_c.write;
            MEM_size     <= grant_req_c.size;
            MEM_addr     <= grant_req_c.addr;
            MEM_data_out <= grant_req_c.data;
            MEM_exec     <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_c) begin
            if (!MEM_write) begin
              if (owner) begin
                O_p1_data       <= MEM_data_in;
                O_p1_data_ready <= 1'b1;
              end else begin
                O_p0_data       <= MEM_data_in;
                O_p0_data_ready <= 1'b1;
              end
            end
            rr_ptr <= !owner;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: round-robin instance (index 0) and fixed-priority instance (index 1).
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        p0_exec [2], p0_write [2], p1_exec [2], p1_write [2];
  logic [1:0]  p0_size [2], p1_size [2];
  logic [15:0] p0_addr [2], p0_data [2], p1_addr [2], p1_data [2];
  logic        p0_ready [2], p1_ready [2], p0_dr [2], p1_dr [2];
  logic [15:0] o_p0_data [2], o_p1_data [2];
  logic        m_ready [2], m_dr [2];
  logic [15:0] m_din [2];
  logic        mem_exec [2], mem_write [2];
  logic [1:0]  mem_size [2];
  logic [15:0] mem_addr [2], mem_dout [2];

  // memory model state
  logic        m_rst;
  int          m_cnt [2], m_gap [2];
  logic        m_rd [2];
  logic [15:0] m_a [2];
  int          mem_lat   = 3;
  int          ready_gap = 0;

  // monitor state
  logic [34:0] log_e [2][128];
  int          log_n [2]     = '{0, 0};
  int          p0_pulses [2] = '{0, 0};
  int          p1_pulses [2] = '{0, 0};
  int          n_double [2]  = '{0, 0};
  logic        prev_exec [2] = '{1'b0, 1'b0};
  logic        saw_ffff [2]  = '{1'b0, 1'b0};

  int n_checks = 0;
  int n_err    = 0;

  mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .I_clk(clk), .I_reset(rst[0]),
    .I_p0_exec(p0_exec[0]), .I_p0_write(p0_write[0]), .I_p0_size(p0_size[0]),
    .I_p0_addr(p0_addr[0]), .I_p0_data(p0_data[0]),
    .O_p0_ready(p0_ready[0]), .O_p0_data(o_p0_data[0]), .O_p0_data_ready(p0_dr[0]),
    .I_p1_exec(p1_exec[0]), .I_p1_write(p1_write[0]), .I_p1_size(p1_size[0]),
    .I_p1_addr(p1_addr[0]), .I_p1_data(p1_data[0]),
    .O_p1_ready(p1_ready[0]), .O_p1_data(o_p1_data[0]), .O_p1_data_ready(p1_dr[0]),
    .MEM_ready(m_ready[0]), .MEM_data_in(m_din[0]), .MEM_data_ready(m_dr[0]),
    .MEM_exec(mem_exec[0]), .MEM_write(mem_write[0]), .MEM_size(mem_size[0]),
    .MEM_addr(mem_addr[0]), .MEM_data_out(mem_dout[0])
  );

  mem_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .I_clk(clk), .I_reset(rst[1]),
    .I_p0_exec(p0_exec[1]), .I_p0_write(p0_write[1]), .I_p0_size(p0_size[1]),
    .I_p0_addr(p0_addr[1]), .I_p0_data(p0_data[1]),
    .O_p0_ready(p0_ready[1]), .O_p0_data(o_p0_data[1]), .O_p0_data_ready(p0_dr[1]),
    .I_p1_exec(p1_exec[1]), .I_p1_write(p1_write[1]), .I_p1_size(p1_size[1]),
    .I_p1_addr(p1_addr[1]), .I_p1_data(p1_data[1]),
    .O_p1_ready(p1_ready[1]), .O_p1_data(o_p1_data[1]), .O_p1_data_ready(p1_dr[1]),
    .MEM_ready(m_ready[1]), .MEM_data_in(m_din[1]), .MEM_data_ready(m_dr[1]),
    .MEM_exec(mem_exec[1]), .MEM_write(mem_write[1]), .MEM_size(mem_size[1]),
    .MEM_addr(mem_addr[1]), .MEM_data_out(mem_dout[1])
  );

  function automatic logic [15:0] rdata(input logic [15:0] a);
    return (a == 16'h0100) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory model: drops ready after accepting exec, answers after mem_lat edges,
  // optionally keeps ready low for ready_gap extra edges after read data.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_dr[k] <= 1'b0;
      if (m_rst) begin
        m_ready[k] <= 1'b1;
        m_cnt[k]   <= 0;
        m_gap[k]   <= 0;
        m_rd[k]    <= 1'b0;
        m_a[k]     <= '0;
        m_din[k]   <= '0;
      end else if (m_cnt[k] != 0) begin
        if (m_cnt[k] == 1) begin
          if (m_rd[k]) begin
            m_dr[k]  <= 1'b1;
            m_din[k] <= rdata(m_a[k]);
          end
          if (m_rd[k] && ready_gap > 0) m_gap[k] <= ready_gap;
          else m_ready[k] <= 1'b1;
        end
        m_cnt[k] <= m_cnt[k] - 1;
      end else if (m_gap[k] != 0) begin
        if (m_gap[k] == 1) m_ready[k] <= 1'b1;
        m_gap[k] <= m_gap[k] - 1;
      end else if (mem_exec[k] && m_ready[k]) begin
        m_ready[k] <= 1'b0;
        m_cnt[k]   <= mem_lat;
        m_rd[k]    <= !mem_write[k];
        m_a[k]     <= mem_addr[k];
      end
    end
  end

  // Monitor: logs every issued request and counts data_ready pulses.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_exec[k]) begin
        if (log_n[k] < 128) log_e[k][log_n[k]] <= {mem_write[k], mem_size[k], mem_dout[k], mem_addr[k]};
        log_n[k] <= log_n[k] + 1;
        if (prev_exec[k]) n_double[k] <= n_double[k] + 1;
      end
      prev_exec[k] <= mem_exec[k];
      if (mem_addr[k] == 16'hFFFF) saw_ffff[k] <= 1'b1;
      if (p0_dr[k]) p0_pulses[k] <= p0_pulses[k] + 1;
      if (p1_dr[k]) p1_pulses[k] <= p1_pulses[k] + 1;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int k);
    p0_exec[k] = 1'b0;
    p1_exec[k] = 1'b0;
    rst[k] = 1'b1;
    repeat (2) @(negedge clk);
    check($sformatf("reset_mem%0d", k),
          {mem_exec[k], mem_write[k], mem_size[k], mem_addr[k], mem_dout[k]}, 64'd0);
    check($sformatf("reset_port%0d", k),
          {p0_ready[k], p1_ready[k], p0_dr[k], p1_dr[k], o_p0_data[k], o_p1_data[k]}, 64'd0);
    rst[k] = 1'b0;
    @(negedge clk);
    check($sformatf("ready_after_reset%0d", k), {p0_ready[k], p1_ready[k]}, 64'd3);
  endtask

  task automatic wait_done(input int k, input string nm);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (p0_ready[k] && p1_ready[k] && m_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_done"}, 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int k; bit rst; int lat;
    bit e0; bit w0; logic [15:0] a0; logic [15:0] d0;
    bit e1; bit w1; logic [15:0] a1; logic [15:0] d1;
    int n;
    logic [15:0] xa1; bit xw1; logic [1:0] xs1; logic [15:0] xd1;
    logic [15:0] xa2; bit xw2; logic [15:0] xd2;
    logic [15:0] xp0d; logic [15:0] xp1d; int xp0p; int xp1p;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int base, b0, b1, cnt_p0, cnt_p1;
    logic [34:0] e;
    string nm;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      p0_exec[k] = 1'b0; p0_write[k] = 1'b0; p0_size[k] = '0; p0_addr[k] = '0; p0_data[k] = '0;
      p1_exec[k] = 1'b0; p1_write[k] = 1'b0; p1_size[k] = '0; p1_addr[k] = '0; p1_data[k] = '0;
    end
    m_rst = 1'b1;

    // single read, simultaneous read/write after reset, then pointer-driven orders
    vecs[0] = '{0, 1'b1, 3, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,
                16'h0100, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 16'h0000, 1, 0};
    vecs[1] = '{0, 1'b1, 3, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 2,
                16'h0010, 1'b0, 2'd2, 16'h0000, 16'h0020, 1'b1, 16'h1234, 16'h5A4A, 16'h0000, 1, 0};
    vecs[2] = '{0, 1'b0, 2, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,
                16'h0030, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h5A6A, 16'h0000, 1, 0};
    vecs[3] = '{0, 1'b0, 2, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 2,
                16'h0020, 1'b1, 2'd1, 16'h1234, 16'h0010, 1'b0, 16'h0000, 16'h5A4A, 16'h0000, 1, 0};
    vecs[4] = '{0, 1'b0, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000, 1,
                16'h0040, 1'b0, 2'd1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h5A4A, 16'h5A1A, 0, 1};
    vecs[5] = '{0, 1'b0, 4, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1, 1'b0, 16'h0060, 16'h0000, 2,
                16'h0050, 1'b0, 2'd2, 16'h0000, 16'h0060, 1'b0, 16'h0000, 16'h5A0A, 16'h5A3A, 1, 1};
    vecs[6] = '{1, 1'b1, 2, 1'b1, 1'b1, 16'h0070, 16'hAAAA, 1'b1, 1'b0, 16'h0080, 16'h0000, 2,
                16'h0070, 1'b1, 2'd2, 16'hAAAA, 16'h0080, 1'b0, 16'h0000, 16'h0000, 16'h5ADA, 0, 1};
    vecs[7] = '{1, 1'b0, 2, 1'b1, 1'b0, 16'h00B0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1,
                16'h00B0, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h5AEA, 16'h5ADA, 1, 0};
    vecs[8] = '{1, 1'b0, 2, 1'b1, 1'b0, 16'h0090, 16'h0000, 1'b1, 1'b1, 16'h00A0, 16'h5555, 2,
                16'h0090, 1'b0, 2'd2, 16'h0000, 16'h00A0, 1'b1, 16'h5555, 16'h5ACA, 16'h5ADA, 1, 0};

    repeat (3) @(negedge clk);
    m_rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      int k;
      k = vecs[i].k;
      if (vecs[i].rst) do_reset(k);
      mem_lat = vecs[i].lat;
      base = log_n[k];
      b0 = p0_pulses[k];
      b1 = p1_pulses[k];
      p0_exec[k] = vecs[i].e0; p0_write[k] = vecs[i].w0; p0_size[k] = MEM_SIZE_WORD;
      p0_addr[k] = vecs[i].a0; p0_data[k] = vecs[i].d0;
      p1_exec[k] = vecs[i].e1; p1_write[k] = vecs[i].w1; p1_size[k] = MEM_SIZE_BYTE;
      p1_addr[k] = vecs[i].a1; p1_data[k] = vecs[i].d1;
      @(negedge clk);
      p0_exec[k] = 1'b0;
      p1_exec[k] = 1'b0;
      nm = $sformatf("v%0d", i);
      wait_done(k, nm);
      check({nm, "_n_exec"}, 64'(log_n[k] - base), 64'(vecs[i].n));
      e = log_e[k][base];
      check({nm, "_addr1"}, 64'(e[15:0]), 64'(vecs[i].xa1));
      check({nm, "_write1"}, 64'(e[34]), 64'(vecs[i].xw1));
      check({nm, "_size1"}, 64'(e[33:32]), 64'(vecs[i].xs1));
      check({nm, "_dout1"}, 64'(e[31:16]), 64'(vecs[i].xd1));
      if (vecs[i].n == 2) begin
        e = log_e[k][base+1];
        check({nm, "_addr2"}, 64'(e[15:0]), 64'(vecs[i].xa2));
        check({nm, "_write2"}, 64'(e[34]), 64'(vecs[i].xw2));
        check({nm, "_dout2"}, 64'(e[31:16]), 64'(vecs[i].xd2));
      end
      check({nm, "_p0_data"}, 64'(o_p0_data[k]), 64'(vecs[i].xp0d));
      check({nm, "_p1_data"}, 64'(o_p1_data[k]), 64'(vecs[i].xp1d));
      check({nm, "_p0_pulses"}, 64'(p0_pulses[k] - b0), 64'(vecs[i].xp0p));
      check({nm, "_p1_pulses"}, 64'(p1_pulses[k] - b1), 64'(vecs[i].xp1p));
    end

    // Exec while busy must be dropped: no second request, 0xFFFF never driven.
    mem_lat = 6;
    base = log_n[0];
    p0_exec[0] = 1'b1; p0_write[0] = 1'b0; p0_size[0] = MEM_SIZE_WORD;
    p0_addr[0] = 16'h0200; p0_data[0] = 16'h0000;
    @(negedge clk);
    check("busy_ready_low", 64'(p0_ready[0]), 64'd0);
    p0_write[0] = 1'b1; p0_addr[0] = 16'hFFFF; p0_data[0] = 16'hDEAD;
    repeat (4) @(negedge clk);
    p0_exec[0] = 1'b0;
    wait_done(0, "busy");
    check("busy_n_exec", 64'(log_n[0] - base), 64'd1);
    check("busy_addr", 64'(log_e[0][base][15:0]), 64'h0200);
    check("busy_no_ffff", 64'(saw_ffff[0]), 64'd0);
    check("busy_p0_data", 64'(o_p0_data[1'b0]), 64'h585A);

    // Fixed priority with both ports re-requesting as soon as they are free.
    mem_lat = 2;
    ready_gap = 2;
    base = log_n[1];
    for (int c = 0; c < 60; c++) begin
      p0_exec[1] = p0_ready[1]; p0_write[1] = 1'b0; p0_addr[1] = 16'h0400; p0_data[1] = 16'h0000;
      p1_exec[1] = p1_ready[1]; p1_write[1] = 1'b0; p1_addr[1] = 16'h0500; p1_data[1] = 16'h0000;
      @(negedge clk);
    end
    p0_exec[1] = 1'b0;
    p1_exec[1] = 1'b0;
    cnt_p0 = 0;
    cnt_p1 = 0;
    for (int j = base; j < log_n[1] && j < 128; j++) begin
      if (log_e[1][j][15:0] == 16'h0400) cnt_p0++;
      if (log_e[1][j][15:0] == 16'h0500) cnt_p1++;
    end
    check("prio_p0_served", 64'(cnt_p0 >= 4), 64'd1);
    check("prio_p1_starved", 64'(cnt_p1), 64'd0);
    ready_gap = 0;
    wait_done(1, "prio_drain");
    check("prio_p1_data", 64'(o_p1_data[1]), 64'h5F5A);

    // Reset during WAIT; the late read data must be ignored.
    mem_lat = 5;
    p1_exec[0] = 1'b1; p1_write[0] = 1'b0; p1_size[0] = MEM_SIZE_BYTE;
    p1_addr[0] = 16'h0300; p1_data[0] = 16'h0000;
    @(negedge clk);
    p1_exec[0] = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (mem_exec[0]) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rst_wait_issue", 64'(seen), 64'd1);
    end
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_mem", {mem_exec[0], mem_addr[0]}, 64'd0);
    check("rst_mid_ready", {p0_ready[0], p1_ready[0]}, 64'd0);
    base = log_n[0];
    b0 = p0_pulses[0];
    b1 = p1_pulses[0];
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_up", {p0_ready[0], p1_ready[0]}, 64'd3);
    repeat (10) @(negedge clk);
    check("rst_late_p0_pulse", 64'(p0_pulses[0] - b0), 64'd0);
    check("rst_late_p1_pulse", 64'(p1_pulses[0] - b1), 64'd0);
    check("rst_late_data", {o_p0_data[0], o_p1_data[0]}, 64'd0);
    check("rst_late_exec", 64'(log_n[0] - base), 64'd0);

    check("single_cycle_exec_rr", 64'(n_double[0]), 64'd0);
    check("single_cycle_exec_fp", 64'(n_double[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 = round-robin arbitration; 1 = port 0 always wins a simultaneous request.
REQ-002 I_clk  in  1  clock; all state changes on rising edge.
REQ-003 I_reset  in  1  reset, synchronous, active-high.
REQ-004 Per port N in {0,1}: I_pN_exec  in  1  request strobe; honoured only while O_pN_ready=1.
REQ-005 Per port: I_pN_write  in  1  1=write, 0=read.
REQ-006 Per port: I_pN_size  in  2  access size code.
REQ-007 Per port: I_pN_addr  in  16  byte address.
REQ-008 Per port: I_pN_data  in  16  write data.
REQ-009 Per port: O_pN_ready  out  1  port buffer empty, can accept a request.
REQ-010 Per port: O_pN_data  out  16  last read data returned to this port.
REQ-011 Per port: O_pN_data_ready  out  1  one-cycle pulse when O_pN_data is updated.
REQ-012 MEM_ready  in  1  memory idle; memory drops it the cycle after sampling MEM_exec and raises it on completion.
REQ-013 MEM_data_in  in  16  memory read data, valid with MEM_data_ready.
REQ-014 MEM_data_ready  in  1  one-cycle read-data-valid pulse.
REQ-015 MEM_exec, MEM_write  out  1 each; MEM_size  out  2; MEM_addr, MEM_data_out  out  16: shared memory request.

Function
REQ-016 Each port SHALL hold a one-entry buffer; I_pN_exec=1 with O_pN_ready=1 captures write/size/addr/data at the edge and marks the port pending.
REQ-017 O_pN_ready SHALL be registered, 0 from the edge that captures a request until the edge that completes it, then 1.
REQ-018 FSM states: IDLE, ISSUE, WAIT.
REQ-019 IDLE: if any port pending and MEM_ready=1, select owner, load MEM_* fields from its buffer, go to ISSUE.
REQ-020 ISSUE: MEM_exec=1 for exactly this one cycle; go to WAIT.
REQ-021 WAIT, read: on MEM_data_ready=1, O_pOwner_data<=MEM_data_in, O_pOwner_data_ready=1 next cycle, clear pending, go to IDLE.
REQ-022 WAIT, write: on MEM_ready=1, clear pending, go to IDLE; no data_ready pulse.
REQ-023 MEM_write/size/addr/data_out SHALL remain stable from ISSUE until return to IDLE; MEM_exec=0 in all states except ISSUE.
REQ-024 Round-robin: after any completion the pointer points to the other port; with both pending, the pointed-to port wins; a single pending port always wins.
REQ-025 FIXED_PRIO=1: port 0 wins whenever both are pending.
REQ-026 Latency: request captured at edge k -> MEM_exec high in cycle k+1 at earliest (IDLE, MEM_ready=1).
REQ-027 I_pN_exec while O_pN_ready=0 SHALL be ignored without side effects.
REQ-028 MEM_data_ready or MEM_ready rising in IDLE or ISSUE SHALL be ignored.
REQ-029 O_pN_data SHALL hold its value until the next read completion for that port.
REQ-030 Completion and new request on the other port in the same cycle: both take effect; the new request is arbitrated from IDLE.

Reset
REQ-031 On I_reset=1 at an edge: state IDLE, both buffers cleared, pointer=port 0, MEM_exec=0, MEM_write=0, MEM_size=0, MEM_addr=0, MEM_data_out=0, O_pN_data=0, O_pN_data_ready=0, O_pN_ready=0.
REQ-032 O_pN_ready SHALL rise at the first edge after I_reset deasserts.
REQ-033 Reset mid-transaction SHALL abandon it; late memory responses after reset SHALL be ignored per REQ-028.

Structure
REQ-034 FSM state encoding, MEM_SIZE_BYTE=1, MEM_SIZE_WORD=2 constants SHALL live in shared package mem_pkg.
REQ-035 Per-port buffer SHALL be sub-module mem_arb_port, instantiated twice.

Verification
REQ-036 Single read: p0 exec addr 0x0100, memory returns 0xBEEF after 3 cycles -> MEM_exec one cycle, O_p0_data=0xBEEF, one O_p0_data_ready pulse, O_p0_ready=1 after.
REQ-037 Simultaneous: p0 read 0x0010, p1 write 0x0020 data 0x1234, same cycle after reset -> p0 served first, then p1 with MEM_data_out=0x1234; repeat -> p1 served first.
REQ-038 FIXED_PRIO=1, both ports continuously re-requesting -> port 0 wins every arbitration.
REQ-039 p0 exec while O_p0_ready=0 with addr 0xFFFF -> no second MEM_exec, address never appears on MEM_addr.
REQ-040 I_reset during WAIT, then MEM_data_ready pulse -> no O_pN_data_ready, O_pN_data=0, ready=1 one edge after reset release.
